nios_multi_timer: RTL and testbench



---
 rtl/nios_timer_pkg.sv | 29 ++
 rtl/nios_timer_channel.sv | 111 +++++++++++
 rtl/nios_multi_timer.sv | 86 ++++++++
 tb/tb_nios_multi_timer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_timer_pkg.sv
// Shared definitions for the multi-channel Nios interval timer: register
// offsets inside a channel window, bit positions and address helpers.
package nios_timer_pkg;

  // Word offsets inside each 4-word channel window.
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_ofs_e;

  // STATUS bit positions.
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // CONTROL bit positions; START/STOP are write-only pulses.
  localparam int CTRL_ITO       = 0;
  localparam int CTRL_CONT      = 1;
  localparam int CTRL_START     = 2;
  localparam int CTRL_STOP      = 3;
  localparam int CTRL_PRESC_LSB = 8;

  // The PENDING register sits right after the last channel window.
  function automatic logic [31:0] pending_addr(input int num_ch);
    return 32'(4 * num_ch);
  endfunction

endpackage

// File: rtl/nios_timer_channel.sv
// One down-counting timer channel: prescaler, counter, run/timeout state,
// snapshot capture and the per-channel interrupt request.
module nios_timer_channel
  import nios_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PRESC_W      = 8,
  parameter logic [31:0] RESET_PERIOD = 32'd99999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_status,
  input  logic        wr_control,
  input  logic        wr_period,
  input  logic        wr_snap,
  input  logic [31:0] writedata,
  output logic [31:0] status_rd,
  output logic [31:0] control_rd,
  output logic [31:0] period_rd,
  output logic [31:0] snap_rd,
  output logic        to_ito
);

  // A zero-width prescaler still needs a 1-bit register; it is held at 0.
  localparam int PW = (PRESC_W > 0) ? PRESC_W : 1;
  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] count, period, snap;
  logic [PW-1:0]    presc, presc_cnt;
  logic             run, to, ito, cont, force_reload;
  logic             tick, timeout, start_req, stop_req;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign tick      = (presc_cnt == presc);
  assign timeout   = run && tick && (count == '0) && !force_reload;
  assign start_req = wr_control && writedata[CTRL_START];
  assign stop_req  = wr_control && writedata[CTRL_STOP];
  assign to_ito    = to && ito;

  // Assemble the software-visible register words.
  always_comb begin
    // NOTE: every output gets a default before field updates, so no path infers a latch.
    status_rd                            = '0;
    status_rd[STAT_TO]                   = to;
    status_rd[STAT_RUN]                  = run;
    control_rd                           = '0;
    control_rd[CTRL_ITO]                 = ito;
    control_rd[CTRL_CONT]                = cont;
    control_rd[CTRL_PRESC_LSB +: PW]     = presc;
    period_rd                            = 32'(period);
    snap_rd                              = 32'(snap);
  end

  // Channel state: configuration, prescaler, counter, RUN and TO.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking throughout so every update sees the pre-edge state.
    if (!reset_n) begin
      count        <= RST_CNT;
      period       <= RST_CNT;
      snap         <= '0;
      presc        <= '0;
      presc_cnt    <= '0;
      run          <= 1'b0;
      to           <= 1'b0;
      ito          <= 1'b0;
      cont         <= 1'b0;
      force_reload <= 1'b0;
    end else begin
      force_reload <= wr_period;
      if (wr_period) period <= writedata[CNT_W-1:0];
      if (wr_snap)   snap   <= count;
      if (wr_control) begin
        ito   <= writedata[CTRL_ITO];
        cont  <= writedata[CTRL_CONT];
        presc <= (PRESC_W > 0) ? writedata[CTRL_PRESC_LSB +: PW] : '0;
      end

      // A timeout in the same cycle as a STATUS write keeps TO set.
      if (timeout)        to <= 1'b1;
      else if (wr_status) to <= 1'b0;

      if (force_reload) begin
        // New PERIOD takes over and the channel stops; a START now is dropped.
        count     <= period;
        presc_cnt <= '0;
        run       <= 1'b0;
      end else begin
        if (run) begin
          if (tick) begin
            presc_cnt <= '0;
            if (count == '0) begin
              count <= period;
              if (!cont) run <= 1'b0;
            end else begin
              count <= count - CNT_W'(1);
            end
          end else begin
            presc_cnt <= presc_cnt + PW'(1);
          end
        end
        if (stop_req && !start_req) run <= 1'b0;
        if (start_req) begin
          run       <= 1'b1;
          presc_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/nios_multi_timer.sv
// NUM_CH interval timers behind one Avalon-MM slave with a registered read
// port, a PENDING summary register and a single ORed interrupt line.
module nios_multi_timer
  import nios_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRESC_W      = 8,
  parameter logic [31:0] RESET_PERIOD = 32'd99999,
  parameter int          AW           = $clog2(4 * NUM_CH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          irq
);

  logic              wr_en;
  logic [31:0]       word_ch;
  reg_ofs_e          ofs;
  logic [NUM_CH-1:0] to_ito;
  logic [31:0]       status_rd  [NUM_CH];
  logic [31:0]       control_rd [NUM_CH];
  logic [31:0]       period_rd  [NUM_CH];
  logic [31:0]       snap_rd    [NUM_CH];
  logic [31:0]       rd_next;

  assign wr_en   = chipselect && !write_n;
  assign word_ch = 32'(address[AW-1:2]);
  assign ofs     = reg_ofs_e'(address[1:0]);
  assign irq     = |to_ito;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_en && (word_ch == 32'(c));

    nios_timer_channel #(
      .CNT_W        (CNT_W),
      .PRESC_W      (PRESC_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_channel (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_status  (sel && (ofs == REG_STATUS)),
      .wr_control (sel && (ofs == REG_CONTROL)),
      .wr_period  (sel && (ofs == REG_PERIOD)),
      .wr_snap    (sel && (ofs == REG_SNAP)),
      .writedata  (writedata),
      .status_rd  (status_rd[c]),
      .control_rd (control_rd[c]),
      .period_rd  (period_rd[c]),
      .snap_rd    (snap_rd[c]),
      .to_ito     (to_ito[c])
    );
  end

  // Read mux: PENDING, a channel register, or 0 for unmapped words.
  always_comb begin
    rd_next = '0;
    if (32'(address) == pending_addr(NUM_CH)) begin
      rd_next = 32'(to_ito);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (word_ch == 32'(c)) begin
          case (ofs)
            REG_STATUS:  rd_next = status_rd[c];
            REG_CONTROL: rd_next = control_rd[c];
            REG_PERIOD:  rd_next = period_rd[c];
            REG_SNAP:    rd_next = snap_rd[c];
          endcase
        end
      end
    end
  end

  // Registered read data, one cycle after the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_nios_multi_timer.sv
// Self-checking bench for nios_multi_timer: timeouts are predicted from
// period/prescale arithmetic, not from the counter implementation.
module tb_nios_multi_timer;

  localparam int NUM_CH       = 4;
  localparam int CNT_W        = 32;
  localparam int PRESC_W      = 8;
  localparam int RESET_PERIOD = 99999;
  localparam int AW           = $clog2(4 * NUM_CH + 1);
  localparam logic [31:0] B_ITO = 32'h1, B_CONT = 32'h2, B_START = 32'h4, B_STOP = 32'h8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  nios_multi_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .PRESC_W      (PRESC_W),
    .RESET_PERIOD (32'(RESET_PERIOD))
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic int ra(input int ch, input int ofs);
    return 4 * ch + ofs;
  endfunction

  task automatic set_addr(input int a);
    address = a[AW-1:0];
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    set_addr(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    set_addr(a); chipselect = 1'b0; write_n = 1'b1;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic apply_reset();
    chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Clear TO, load PERIOD, let the forced reload pass, then START.
  task automatic start_channel(input int ch, input int p, input int s, input bit cont, input bit ito);
    bus_write(ra(ch, 0), 32'd0);
    bus_write(ra(ch, 2), 32'(p));
    idle(1);
    bus_write(ra(ch, 1), B_START | (cont ? B_CONT : 32'd0) | (ito ? B_ITO : 32'd0) | (32'(s) << 8));
  endtask

  // Watch irq and STATUS for n cycles after RUN rises. A timeout lands
  // (p+1)*(s+1) cycles after RUN; in continuous mode TO is cleared after each.
  task automatic watch(input int ch, input int p, input int s, input bit cont, input bit ito, input int n);
    int   t;
    int   j;
    int   exp_st;
    logic exp_irq;
    t = (p + 1) * (s + 1);
    set_addr(ra(ch, 0)); writedata = '0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      j = k - 1;
      if (cont) begin
        exp_irq = ito && (k % t == 0);
        exp_st  = 2 + ((j > 0 && j % t == 0) ? 1 : 0);
      end else begin
        exp_irq = ito && (k >= t);
        exp_st  = ((j < t) ? 2 : 0) + ((j >= t) ? 1 : 0);
      end
      n_vec++;
      if (irq !== exp_irq) begin
        n_err++;
        $display("FAIL watch_irq ch%0d p=%0d s=%0d cyc=%0d: got %b expected %b", ch, p, s, k, irq, exp_irq);
      end
      n_vec++;
      if (readdata !== 32'(exp_st)) begin
        n_err++;
        $display("FAIL watch_status ch%0d p=%0d s=%0d cyc=%0d: got %h expected %h", ch, p, s, k, readdata, exp_st);
      end
      if (cont && (k % t == 0)) begin chipselect = 1'b1; write_n = 1'b0; end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset_readback();
    logic [31:0] rd;
    logic [31:0] exp;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int o = 0; o < 4; o++) begin
        bus_read(ra(ch, o), rd);
        exp = (o == 2) ? 32'(RESET_PERIOD) : 32'd0;
        n_vec++;
        if (rd !== exp) begin n_err++; $display("FAIL reset_reg ch%0d ofs%0d: got %h expected %h", ch, o, rd, exp); end
      end
    end
    for (int a = 4 * NUM_CH; a < (1 << AW); a++) begin
      bus_read(a, rd);
      n_vec++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL reset_pending_unmapped addr%0d: got %h expected 0", a, rd); end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    apply_reset();
    start_channel(0, 9, 0, 1'b0, 1'b1);
    watch(0, 9, 0, 1'b0, 1'b1, 14);
    bus_read(ra(0, 1), rd);
    n_vec++;
    if (rd !== B_ITO) begin n_err++; $display("FAIL oneshot_control: got %h expected %h", rd, B_ITO); end
    bus_read(4 * NUM_CH, rd);
    n_vec++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL oneshot_pending: got %h expected 1", rd); end
    bus_write(ra(0, 0), 32'd0);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_prescale_cont();
    logic [31:0] rd;
    apply_reset();
    start_channel(1, 4, 3, 1'b1, 1'b1);
    watch(1, 4, 3, 1'b1, 1'b1, 62);
    bus_read(ra(1, 1), rd);
    n_vec++;
    if (rd !== (B_ITO | B_CONT | 32'h300)) begin n_err++; $display("FAIL presc_control: got %h expected %h", rd, B_ITO | B_CONT | 32'h300); end
  endtask

  task automatic test_random();
    int   ch, p, s, t;
    bit   cont;
    logic [31:0] rd;
    for (int it = 0; it < 8; it++) begin
      ch   = $urandom_range(0, NUM_CH - 1);
      p    = $urandom_range(0, 12);
      s    = $urandom_range(0, 3);
      cont = 1'($urandom_range(0, 1));
      t    = (p + 1) * (s + 1);
      apply_reset();
      start_channel(ch, p, s, cont, 1'b1);
      watch(ch, p, s, cont, 1'b1, cont ? 3 * t + 2 : t + 3);
      bus_read(ra(ch, 2), rd);
      n_vec++;
      if (rd !== 32'(p)) begin n_err++; $display("FAIL random_period ch%0d: got %h expected %h", ch, rd, p); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    apply_reset();
    bus_write(ra(2, 2), 32'd11);
    bus_write(ra(3, 2), 32'd10);
    idle(1);
    bus_write(ra(2, 1), B_START | B_ITO);
    bus_write(ra(3, 1), B_START | B_ITO);
    idle(10);
    bus_write(ra(2, 0), 32'd0);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL collide_irq: got %b expected 1", irq); end
    bus_read(4 * NUM_CH, rd);
    n_vec++;
    if (rd !== 32'hC) begin n_err++; $display("FAIL collide_pending: got %h expected c", rd); end
    bus_read(ra(2, 0), rd);
    n_vec++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL collide_to_kept: got %h expected 1", rd); end
    bus_write(ra(2, 0), 32'd0);
    bus_read(ra(2, 0), rd);
    n_vec++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL collide_to_clear: got %h expected 0", rd); end
    bus_read(4 * NUM_CH, rd);
    n_vec++;
    if (rd !== 32'h8) begin n_err++; $display("FAIL collide_pending_after: got %h expected 8", rd); end
  endtask

  task automatic test_snapshot();
    int s, d, x, exp;
    logic [31:0] rd;
    apply_reset();
    s = $urandom_range(0, 3);
    d = $urandom_range(0, 40);
    x = $urandom_range(1, 5000);
    start_channel(0, 1000, s, 1'b1, 1'b0);
    idle(d);
    bus_write(ra(0, 3), 32'd0);
    exp = 1000 - d / (s + 1);
    bus_read(ra(0, 3), rd);
    n_vec++;
    if (rd !== 32'(exp)) begin n_err++; $display("FAIL snap_value s=%0d d=%0d: got %0d expected %0d", s, d, rd, exp); end
    bus_write(ra(0, 2), 32'(x));
    idle(1);
    bus_read(ra(0, 0), rd);
    n_vec++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL reload_run_clear: got %h expected 0", rd); end
    bus_write(ra(0, 3), 32'd0);
    bus_read(ra(0, 3), rd);
    n_vec++;
    if (rd !== 32'(x)) begin n_err++; $display("FAIL reload_count: got %0d expected %0d", rd, x); end
    bus_write(ra(0, 1), B_START | B_STOP);
    bus_read(ra(0, 0), rd);
    n_vec++;
    if (rd !== 32'h2) begin n_err++; $display("FAIL start_stop_both: got %h expected 2", rd); end
    bus_write(ra(0, 1), B_STOP);
    bus_read(ra(0, 0), rd);
    n_vec++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL stop_only: got %h expected 0", rd); end
  endtask

  task automatic test_reset_mid();
    bit found;
    apply_reset();
    start_channel(0, 3, 0, 1'b1, 1'b1);
    set_addr(ra(0, 0));
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL midreset_irq_wait: got no irq within 50 cycles expected irq"); end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    n_vec++;
    if (readdata !== 32'd0) begin n_err++; $display("FAIL midreset_readdata: got %h expected 0", readdata); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset_readback();
  endtask

  initial begin
    apply_reset();
    test_reset_readback();
    test_oneshot();
    test_prescale_cont();
    test_random();
    test_collision();
    test_snapshot();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
